// File: rtl/treino_pkg.sv
// rtl/treino_pkg.sv - shared types, FP16 constants and helpers for the training sequencer
//
// Purpose : state encoding of the training FSM and the FP16 equality rule
//           used when checking datapath outputs against desired outputs.
// Contents: estado_t, FP16_ZERO, FP16_NZERO, FP16_UM, fp16_igual().
package treino_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        FIM   = 3'd4
    } estado_t;

    localparam logic [15:0] FP16_ZERO  = 16'h0000;
    localparam logic [15:0] FP16_NZERO = 16'h8000;
    localparam logic [15:0] FP16_UM    = 16'h3C00;

    // Bit-equal words match; +0 and -0 also match each other.
    function automatic logic fp16_igual(input logic [15:0] a, input logic [15:0] b);
        return (a == b) || ((a == FP16_ZERO || a == FP16_NZERO) &&
                            (b == FP16_ZERO || b == FP16_NZERO));
    endfunction

endpackage

// File: rtl/comparador_amostras.sv
// rtl/comparador_amostras.sv - combinational mismatch counter over one epoch of samples
//
// Purpose : compares each captured datapath output with its desired output
//           using the FP16 equality rule and returns how many differ.
// Ports   : resultado_i  N_AMOSTRAS x TAM captured outputs
//           desejado_i   N_AMOSTRAS x TAM desired outputs
//           n_erros_o    number of mismatching samples
module comparador_amostras
    import treino_pkg::*;
#(
    parameter  int TAM        = 16,
    parameter  int N_AMOSTRAS = 4,
    localparam int RW         = $clog2(N_AMOSTRAS + 1)
) (
    input  logic [N_AMOSTRAS*TAM-1:0] resultado_i,
    input  logic [N_AMOSTRAS*TAM-1:0] desejado_i,
    output logic [RW-1:0]             n_erros_o
);

    always_comb begin
        n_erros_o = '0;
        for (int i = 0; i < N_AMOSTRAS; i++) begin
            if (!fp16_igual(resultado_i[i*TAM +: TAM], desejado_i[i*TAM +: TAM])) begin
                n_erros_o = n_erros_o + RW'(1);
            end
        end
    end

endmodule

// File: rtl/treino_ctrl.sv
// rtl/treino_ctrl.sv - perceptron training sequencer driving the epoch datapath
//
// Purpose : loads initial weights, launches one epoch at a time, checks the
//           outputs against the desired outputs and stops on convergence or
//           after MAX_EPOCAS epochs. Optional WAIT watchdog under the macro
//           TREINO_TIMEOUT_EN.
// Ports   : clk, reset (async, active-high)
//           start, w0_init..w2_init, d               harness side inputs
//           epoca_start / epoca_done, epoca_result,
//           epoca_w0..epoca_w2, w0..w2                datapath handshake and weights
//           busy, done, convergiu, epocas, erros, timeout   status (all registered)
module treino_ctrl
    import treino_pkg::*;
#(
    parameter  int TAM            = 16,
    parameter  int N_AMOSTRAS     = 4,
    parameter  int MAX_EPOCAS     = 32,
    parameter  int TIMEOUT_CICLOS = 64,
    localparam int EW             = $clog2(MAX_EPOCAS + 1),
    localparam int RW             = $clog2(N_AMOSTRAS + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [TAM-1:0]            w0_init,
    input  logic [TAM-1:0]            w1_init,
    input  logic [TAM-1:0]            w2_init,
    input  logic [N_AMOSTRAS*TAM-1:0] d,
    output logic                      epoca_start,
    input  logic                      epoca_done,
    input  logic [N_AMOSTRAS*TAM-1:0] epoca_result,
    input  logic [TAM-1:0]            epoca_w0,
    input  logic [TAM-1:0]            epoca_w1,
    input  logic [TAM-1:0]            epoca_w2,
    output logic [TAM-1:0]            w0,
    output logic [TAM-1:0]            w1,
    output logic [TAM-1:0]            w2,
    output logic                      busy,
    output logic                      done,
    output logic                      convergiu,
    output logic [EW-1:0]             epocas,
    output logic [RW-1:0]             erros,
    output logic                      timeout
);

    estado_t state_q, state_d;

    logic epoca_start_q, epoca_start_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic [TAM-1:0]            w0_q, w1_q, w2_q;
    logic [N_AMOSTRAS*TAM-1:0] resultado_q;
    logic [EW-1:0]             epocas_q;
    logic [RW-1:0]             erros_q;
    logic                      convergiu_q;
    logic [RW-1:0]             n_erros;
    logic                      wd_expirou;

    comparador_amostras #(
        .TAM        (TAM),
        .N_AMOSTRAS (N_AMOSTRAS)
    ) u_comparador (
        .resultado_i (resultado_q),
        .desejado_i  (d),
        .n_erros_o   (n_erros)
    );

`ifdef TREINO_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CICLOS + 1);
    logic [CW-1:0] wd_cnt_q;
    logic          timeout_q;

    // Counter restarts while in RUN, so it reads 0 in the first WAIT cycle.
    assign wd_expirou = (state_q == WAIT) && !epoca_done &&
                        (wd_cnt_q == CW'(TIMEOUT_CICLOS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == WAIT) begin
                wd_cnt_q <= wd_cnt_q + CW'(1);
            end else begin
                wd_cnt_q <= '0;
            end
            if (state_q == IDLE && start) begin
                timeout_q <= 1'b0;
            end else if (wd_expirou) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CICLOS > 0);
    assign wd_expirou = 1'b0;
    assign timeout    = 1'b0;
`endif

    // State register plus registered Moore outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            epoca_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            epoca_start_q <= epoca_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = RUN;
            RUN:   state_d = WAIT;
            WAIT: begin
                if (epoca_done) begin
                    state_d = CHECK;
                end else if (wd_expirou) begin
                    state_d = FIM;
                end
            end
            CHECK: begin
                if (n_erros == '0 || epocas_q == EW'(MAX_EPOCAS)) begin
                    state_d = FIM;
                end else begin
                    state_d = RUN;
                end
            end
            FIM:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with it once registered.
    always_comb begin
        epoca_start_d = (state_d == RUN);
        busy_d        = (state_d != IDLE);
        done_d        = (state_d == FIM);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w0_q        <= '0;
            w1_q        <= '0;
            w2_q        <= '0;
            resultado_q <= '0;
            epocas_q    <= '0;
            erros_q     <= '0;
            convergiu_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        w0_q        <= w0_init;
                        w1_q        <= w1_init;
                        w2_q        <= w2_init;
                        epocas_q    <= '0;
                        erros_q     <= '0;
                        convergiu_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (epoca_done) begin
                        w0_q        <= epoca_w0;
                        w1_q        <= epoca_w1;
                        w2_q        <= epoca_w2;
                        resultado_q <= epoca_result;
                        epocas_q    <= epocas_q + EW'(1);
                    end
                end
                CHECK: begin
                    erros_q     <= n_erros;
                    convergiu_q <= (n_erros == '0);
                end
                default: ;
            endcase
        end
    end

    assign epoca_start = epoca_start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign w0          = w0_q;
    assign w1          = w1_q;
    assign w2          = w2_q;
    assign epocas      = epocas_q;
    assign erros       = erros_q;
    assign convergiu   = convergiu_q;

endmodule

// File: tb/tb_treino_ctrl.sv
// tb/tb_treino_ctrl.sv - self-checking bench for treino_ctrl with a behavioural epoch datapath
module tb_treino_ctrl;

    localparam int TAM  = 16;
    localparam int N    = 4;
    localparam int MAXE = 4;
    localparam int TO   = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [TAM-1:0]    w0_init, w1_init, w2_init;
    logic [N*TAM-1:0]  d;
    logic              epoca_start;
    logic              epoca_done;
    logic [N*TAM-1:0]  epoca_result;
    logic [TAM-1:0]    epoca_w0, epoca_w1, epoca_w2;
    logic [TAM-1:0]    w0, w1, w2;
    logic              busy, done, convergiu, timeout;
    logic [2:0]        epocas;
    logic [2:0]        erros;

    int checks   = 0;
    int failures = 0;

    // Datapath model controls: mismatch schedule per epoch and behaviour knobs.
    int       sched [4];
    bit       model_en    = 1'b0;
    bit       spurious_en = 1'b0;
    bit       nzero0      = 1'b0;
    int       n_starts    = 0;
    logic [15:0] mw0, mw1, mw2;

    treino_ctrl #(
        .TAM            (TAM),
        .N_AMOSTRAS     (N),
        .MAX_EPOCAS     (MAXE),
        .TIMEOUT_CICLOS (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .w0_init      (w0_init),
        .w1_init      (w1_init),
        .w2_init      (w2_init),
        .d            (d),
        .epoca_start  (epoca_start),
        .epoca_done   (epoca_done),
        .epoca_result (epoca_result),
        .epoca_w0     (epoca_w0),
        .epoca_w1     (epoca_w1),
        .epoca_w2     (epoca_w2),
        .w0           (w0),
        .w1           (w1),
        .w2           (w2),
        .busy         (busy),
        .done         (done),
        .convergiu    (convergiu),
        .epocas       (epocas),
        .erros        (erros),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // Epoch datapath model: answers each launch after a random latency with an
    // output vector holding exactly sched[epoch] wrong samples.
    initial begin
        int e, lat, s, k, mism;
        logic [N*TAM-1:0] r;
        logic [15:0] smp;
        epoca_done   = 1'b0;
        epoca_result = '0;
        epoca_w0 = '0; epoca_w1 = '0; epoca_w2 = '0;
        forever begin
            @(negedge clk);
            if (model_en && epoca_start === 1'b1) begin
                e = n_starts;
                n_starts++;
                if (spurious_en) begin
                    // Same cycle as epoca_start: must be ignored by the controller.
                    epoca_done   = 1'b1;
                    epoca_result = ~d;
                    epoca_w0 = 16'hDEAD; epoca_w1 = 16'hBEEF; epoca_w2 = 16'hCAFE;
                    @(negedge clk);
                    epoca_done = 1'b0;
                end else begin
                    @(negedge clk);
                end
                lat = $urandom_range(1, 4);
                repeat (lat - 1) @(negedge clk);
                mism = sched[(e < 4) ? e : 3];
                r = d;
                s = $urandom_range(0, N - 1);
                for (int j = 0; j < N; j++) begin
                    k = (s + j) % N;
                    smp = d[k*TAM +: TAM];
                    if (j < mism) begin
                        smp = smp ^ (16'h0001 << $urandom_range(0, 14));
                    end else if (smp[14:0] == 15'h0 && (nzero0 || $urandom_range(0, 1) == 1)) begin
                        smp[15] = ~smp[15];
                    end
                    r[k*TAM +: TAM] = smp;
                end
                mw0 = 16'($urandom); mw1 = 16'($urandom); mw2 = 16'($urandom);
                epoca_done   = 1'b1;
                epoca_result = r;
                epoca_w0 = mw0; epoca_w1 = mw1; epoca_w2 = mw2;
                @(negedge clk);
                epoca_done   = 1'b0;
                epoca_result = {N{16'h7E00}};
                epoca_w0 = 16'h1111; epoca_w1 = 16'h2222; epoca_w2 = 16'h3333;
                checks++;
                if (w0 !== mw0 || w1 !== mw1 || w2 !== mw2) begin
                    failures++;
                    $display("FAIL epoch_weights epoch=%0d got=%h/%h/%h exp=%h/%h/%h",
                             e + 1, w0, w1, w2, mw0, mw1, mw2);
                end
            end
        end
    end

    task automatic run_training(input string name);
        int exp_ep, exp_err, cyc;
        bit exp_conv;
        exp_ep = MAXE;
        for (int i = 0; i < MAXE; i++) begin
            if (sched[i] == 0) begin
                exp_ep = i + 1;
                break;
            end
        end
        exp_err  = sched[exp_ep-1];
        exp_conv = (exp_err == 0);
        n_starts = 0;
        model_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (epoca_start !== 1'b1 || busy !== 1'b1 || convergiu !== 1'b0 ||
            epocas !== 3'd0 || erros !== 3'd0) begin
            failures++;
            $display("FAIL %s_launch start=%b busy=%b conv=%b ep=%0d err=%0d exp=1 1 0 0 0",
                     name, epoca_start, busy, convergiu, epocas, erros);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done_wait got=no_done exp=done_within_300", name);
        end else begin
            if (convergiu !== exp_conv || epocas !== 3'(exp_ep) || erros !== 3'(exp_err) ||
                n_starts != exp_ep || w0 !== mw0 || w1 !== mw1 || w2 !== mw2 || timeout !== 1'b0) begin
                failures++;
                $display("FAIL %s_result conv=%b ep=%0d err=%0d launches=%0d w0=%h to=%b exp conv=%b ep=%0d err=%0d launches=%0d w0=%h to=0",
                         name, convergiu, epocas, erros, n_starts, w0, timeout,
                         exp_conv, exp_ep, exp_err, exp_ep, mw0);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s_end busy=%b done=%b exp=0 0", name, busy, done);
        end
        model_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        w0_init = '0; w1_init = '0; w2_init = '0;
        d = '0;
        #1;
        checks++;
        if ({w0, w1, w2, epoca_start, busy, done, convergiu, epocas, erros, timeout} !== '0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0",
                     {w0, w1, w2, epoca_start, busy, done, convergiu, epocas, erros, timeout});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_or_first_epoch();
        w0_init = 16'h3C00; w1_init = 16'h3C00; w2_init = 16'h3C00;
        d = {16'h3C00, 16'h3C00, 16'h3C00, 16'h0000};
        sched = '{0, 0, 0, 0};
        spurious_en = 1'b0;
        nzero0 = 1'b0;
        run_training("or_epoch1");
    endtask

    task automatic test_converge_after_3();
        w0_init = 16'($urandom); w1_init = 16'($urandom); w2_init = 16'($urandom);
        for (int i = 0; i < N; i++) d[i*TAM +: TAM] = rand_word();
        sched = '{1, 1, 1, 0};
        spurious_en = 1'b1;
        run_training("conv_ep4");
    endtask

    task automatic test_epoch_limit();
        for (int i = 0; i < N; i++) d[i*TAM +: TAM] = rand_word();
        sched = '{2, 2, 2, 2};
        spurious_en = 1'b0;
        run_training("max_epochs");
    endtask

    task automatic test_signed_zero();
        d = {16'h4000, 16'hC400, 16'h3C00, 16'h0000};
        sched = '{0, 0, 0, 0};
        nzero0 = 1'b1;
        run_training("signed_zero");
        nzero0 = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        model_en = 1'b0;
        w0_init = 16'($urandom) | 16'h1; w1_init = 16'h1234; w2_init = 16'h5678;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({w0, w1, w2, epoca_start, busy, done, convergiu, epocas, erros, timeout} !== '0) begin
            failures++;
            $display("FAIL reset_in_wait got=%h exp=0",
                     {w0, w1, w2, epoca_start, busy, done, convergiu, epocas, erros, timeout});
        end
        @(negedge clk);
        reset = 1'b0;
        epoca_done = 1'b1;
        epoca_w0 = 16'hAAAA;
        @(negedge clk);
        epoca_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || epoca_start !== 1'b0 || epocas !== 3'd0 || w0 !== 16'h0) begin
            failures++;
            $display("FAIL post_reset_idle busy=%b start=%b ep=%0d w0=%h exp=0 0 0 0000",
                     busy, epoca_start, epocas, w0);
        end
        for (int i = 0; i < N; i++) d[i*TAM +: TAM] = rand_word();
        sched = '{3, 0, 0, 0};
        run_training("after_reset");
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            w0_init = 16'($urandom); w1_init = 16'($urandom); w2_init = 16'($urandom);
            for (int i = 0; i < N; i++) d[i*TAM +: TAM] = rand_word();
            for (int i = 0; i < MAXE; i++) sched[i] = $urandom_range(0, N);
            spurious_en = ($urandom_range(0, 1) == 1);
            run_training("random");
        end
    endtask

`ifdef TREINO_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        model_en = 1'b0;
        w0_init = 16'h4242; w1_init = 16'h0101; w2_init = 16'h0202;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done !== 1'b1 || cyc != TO + 1 || timeout !== 1'b1 || convergiu !== 1'b0 ||
            epocas !== 3'd0 || w0 !== 16'h4242) begin
            failures++;
            $display("FAIL timeout done=%b cyc=%0d to=%b conv=%b ep=%0d w0=%h exp=1 %0d 1 0 0 4242",
                     done, cyc, timeout, convergiu, epocas, w0, TO + 1);
        end
        @(negedge clk);
    endtask
`else
    task automatic test_timeout();
        model_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (done === 1'b1 || timeout !== 1'b0) break;
        end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL no_watchdog busy=%b done=%b to=%b exp=1 0 0", busy, done, timeout);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_or_first_epoch();
        test_converge_after_3();
        test_epoch_limit();
        test_signed_zero();
        test_reset_in_wait();
        test_random();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/treino_ctrl.md
# treino_ctrl

Training sequencer for the perceptron epoch datapath (`epoca`). It loads initial FP16 weights, fires the datapath one epoch at a time and checks each epoch's outputs against the desired outputs. It repeats until every sample matches or an epoch limit is reached. It sits between the system/test harness and `epoca`, and owns the weight registers that feed the datapath between epochs.

## Interface
Parameters:
- `TAM`, 16: word width; IEEE-754 half precision.
- `N_AMOSTRAS`, 4: samples per epoch.
- `MAX_EPOCAS`, 32: epoch limit; must be ≥1.
- `TIMEOUT_CICLOS`, 64: watchdog limit in cycles. Used only with `TREINO_TIMEOUT_EN`.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  level, sampled in IDLE only; begins training.
- `w0_init`, `w1_init`, `w2_init`  in  TAM each  initial weights, latched on accepted `start`.
- `d`  in  N_AMOSTRAS×TAM  desired output per sample; held stable while `busy`.
- `epoca_start`  out  1  one-cycle pulse that launches one epoch in the datapath.
- `epoca_done`  in  1  one-cycle pulse from the datapath; `epoca_result` and the `epoca_w*` inputs are valid in that cycle.
- `epoca_result`  in  N_AMOSTRAS×TAM  datapath outputs.
- `epoca_w0`, `epoca_w1`, `epoca_w2`  in  TAM each  updated weights.
- `w0`, `w1`, `w2`  out  TAM each  current weights driven to the datapath.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of training.
- `convergiu`  out  1  valid from `done` until the next accepted `start`; 1 means all samples matched.
- `epocas`  out  $clog2(MAX_EPOCAS+1)  number of epochs completed.
- `erros`  out  $clog2(N_AMOSTRAS+1)  mismatch count from the last checked epoch.
- `timeout`  out  1  sticky watchdog flag; tied 0 when the watchdog is compiled out.

## Operation
- All outputs are registered (Moore style).
- FSM states: IDLE, RUN, WAIT, CHECK, FIM.
- IDLE:
  - When `start`=1: latch the `w*_init` inputs into `w*`, clear `epocas`, `erros`, `convergiu` and `timeout`, then go to RUN.
- RUN:
  - Assert `epoca_start` for exactly one cycle, then go to WAIT.
- WAIT:
  - When `epoca_done`=1: capture `epoca_w*` into `w*` and `epoca_result` into an internal register, increment `epocas`, then go to CHECK.
- CHECK:
  - Compare each of the N samples with `d[i]`. Two words match if they are bit-equal, or if both are ±0 (`16'h0000` and `16'h8000` are equal).
  - Load `erros` with the mismatch count.
  - If `erros`=0: set `convergiu`=1 and go to FIM.
  - Else if `epocas`=MAX_EPOCAS: go to FIM with `convergiu`=0.
  - Else: go to RUN.
- FIM:
  - Pulse `done` for one cycle, then go to IDLE.
  - `w*`, `epocas`, `erros` and `convergiu` hold their values until the next accepted `start`.
- Ignored inputs:
  - `start` outside IDLE.
  - `epoca_done` outside WAIT, including a `done` in the same cycle as `epoca_start`.

## Timing
- Reset value of every output is 0: `w0`–`w2`, `epoca_start`, `busy`, `done`, `convergiu`, `epocas`, `erros`, `timeout`.
- Reset takes effect immediately, in any state; the FSM returns to IDLE and no further `epoca_start` is issued.
- Start to launch: `start` sampled at edge k → `epoca_start` high during cycle k+1.
- Per-epoch controller overhead: RUN (1 cycle) + WAIT (≥1 cycle) + CHECK (1 cycle). The next `epoca_start` comes 2 cycles after the `epoca_done` edge.
- End of training: `done` is high in the cycle after CHECK. `busy` falls one cycle after `done`.
- `w*` change only at the `start` edge and at `epoca_done` edges; they are stable throughout RUN and WAIT.

## Configuration
- `TREINO_TIMEOUT_EN` defined:
  - A WAIT-cycle counter clears on entry to WAIT.
  - If the counter reaches TIMEOUT_CICLOS without `epoca_done`: set `timeout`=1 and go to FIM with `convergiu`=0. `epocas` and `w*` are left unchanged.
- `TREINO_TIMEOUT_EN` undefined:
  - No counter is built; `timeout` is constant 0.
  - WAIT waits indefinitely for `epoca_done`.

## Structure
- Package `treino_pkg` holds:
  - the state enum `estado_t`;
  - FP16 constants `FP16_ZERO`=16'h0000, `FP16_NZERO`=16'h8000, `FP16_UM`=16'h3C00;
  - function `fp16_igual`.
- Sub-module `comparador_amostras`: combinational compare of N results against `d`; outputs the mismatch count.

## Test plan
- OR task with a datapath model that matches on epoch 1:
  - Stimulus: `w*_init`=3C00, d={0000,3C00,3C00,3C00}.
  - Response: one `epoca_start`; `done` with `convergiu`=1, `epocas`=1, `erros`=0.
- Model mismatches 1 sample for 3 epochs, then matches:
  - Response: 4 `epoca_start` pulses; `epocas`=4, `convergiu`=1.
  - Check `w*` after each epoch equal the model's `epoca_w*`.
- MAX_EPOCAS=4, model never matches (2 samples wrong):
  - Response: `done` after the 4th CHECK; `convergiu`=0, `epocas`=4, `erros`=2.
- Signed zero:
  - Stimulus: result[0]=8000 against d[0]=0000, all other samples equal.
  - Response: `erros`=0, `convergiu`=1.
- `reset` pulsed during WAIT:
  - Response: all outputs 0 at once; a later `epoca_done` is ignored; a fresh `start` trains normally.
- With `TREINO_TIMEOUT_EN` and TIMEOUT_CICLOS=8, model never returns `epoca_done`:
  - Response: `timeout`=1 and a `done` pulse after 8 WAIT cycles; `convergiu`=0, `epocas`=0.
